// File: rtl/hpu_pkg.sv
// Shared constants for the HPU stream datapath.
//   AXIS_DATA_W      : width of the accelerator result stream
//   RESULT_PKT_BEATS : beats in one dst_buf result frame
//   ptr_w()          : pointer width for a power-of-two depth
package hpu_pkg;

    localparam int unsigned AXIS_DATA_W      = 64;
    localparam int unsigned RESULT_PKT_BEATS = 32;

    function automatic int unsigned ptr_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/dst_stream_fifo_if.sv
// Handshake bundle around dst_stream_fifo.
//   s_* : upstream beat from the accelerator (M_AXIS side)
//   m_* : downstream beat toward the DMA S2MM port
// Modport slave is the FIFO's view; master is the surrounding environment's view.
interface dst_stream_fifo_if
    import hpu_pkg::*;
#(
    parameter int unsigned DATA_W = AXIS_DATA_W
);

    logic                  s_valid;
    logic [DATA_W-1:0]     s_data;
    logic                  s_last;
    logic                  s_ready;

    logic                  m_valid;
    logic [DATA_W-1:0]     m_data;
    logic                  m_last;
    logic [DATA_W/8-1:0]   m_strb;
    logic                  m_ready;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, m_strb
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_strb
    );

endinterface

// File: rtl/dst_stream_fifo_mem.sv
// Register-file storage for dst_stream_fifo: one synchronous write port and
// one asynchronous read port (first-word fall-through).
//   clk   : stream clock
//   we    : write enable
//   waddr : write pointer
//   wdata : {last, data} word
//   raddr : read pointer
//   rdata : word at raddr
module dst_stream_fifo_mem
    import hpu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = AXIS_DATA_W + 1
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage needs no reset: contents are only visible while level != 0.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dst_stream_fifo.sv
// Elastic buffer between the accelerator result stream and the DMA S2MM port,
// with per-packet length checking against the fixed result frame.
//   clk, rst : stream clock, asynchronous active-high reset
//   clear    : synchronous flush of data and statistics
//   bus      : s_* upstream handshake, m_* downstream handshake
//   level    : entries currently stored
//   pkt_cnt  : packets accepted since the last clear
//   beat_cnt : beats accepted in the current input packet
//   len_err  : sticky packet-length violation
module dst_stream_fifo
    import hpu_pkg::*;
#(
    parameter int unsigned DATA_W    = AXIS_DATA_W,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PKT_BEATS = RESULT_PKT_BEATS,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    dst_stream_fifo_if.slave              bus,
    output logic [ptr_w(DEPTH):0]         level,
    output logic [CNT_W-1:0]              pkt_cnt,
    output logic [ptr_w(PKT_BEATS):0]     beat_cnt,
    output logic                          len_err
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned BW = ptr_w(PKT_BEATS) + 1;
    localparam int unsigned MW = DATA_W + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [MW-1:0] rd_word;
    logic          push_c;
    logic          pop_c;
    logic [BW:0]   beat_nxt_c;
    logic          frame_hit_c;
    logic          beat_sat_c;

    // Flow control is derived from the registered level only.
    assign bus.s_ready = (level != LW'(DEPTH));
    assign bus.m_valid = (level != LW'(0));
    assign bus.m_strb  = '1;
    assign {bus.m_last, bus.m_data} = rd_word;

    // clear wins over both handshakes: a beat offered during clear is dropped.
    assign push_c = bus.s_valid & bus.s_ready & ~clear;
    assign pop_c  = bus.m_valid & bus.m_ready & ~clear;

    // One bit wider than beat_cnt so the compare stays correct at saturation.
    assign beat_nxt_c  = {1'b0, beat_cnt} + (BW+1)'(1);
    assign frame_hit_c = (beat_nxt_c == (BW+1)'(PKT_BEATS));
    assign beat_sat_c  = &beat_cnt;

    dst_stream_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (MW)
    ) u_mem (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr),
        .wdata ({bus.s_last, bus.s_data}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // Pointers, occupancy and length statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pkt_cnt  <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pkt_cnt  <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (bus.s_last) begin
                    if (!frame_hit_c) begin
                        len_err <= 1'b1;
                    end
                    beat_cnt <= '0;
                    pkt_cnt  <= pkt_cnt + CNT_W'(1);
                end else begin
                    // Reaching the frame length without last means too long.
                    if (frame_hit_c) begin
                        len_err <= 1'b1;
                    end
                    if (!beat_sat_c) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
            end

            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push_c, pop_c})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_dst_stream_fifo.sv
// Directed self-checking bench for dst_stream_fifo.
module tb_dst_stream_fifo;
    import hpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [4:0]  level;
    logic [15:0] pkt_cnt;
    logic [5:0]  beat_cnt;
    logic        len_err;

    int n_cmp = 0;
    int n_err = 0;

    dst_stream_fifo_if #(.DATA_W(64)) bus ();

    dst_stream_fifo #(
        .DATA_W    (64),
        .DEPTH     (16),
        .PKT_BEATS (32),
        .CNT_W     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .bus      (bus),
        .level    (level),
        .pkt_cnt  (pkt_cnt),
        .beat_cnt (beat_cnt),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_level"},  64'(level),       64'd0);
        chk({tag, "_mvalid"}, 64'(bus.m_valid), 64'd0);
        chk({tag, "_sready"}, 64'(bus.s_ready), 64'd1);
        chk({tag, "_pkt"},    64'(pkt_cnt),     64'd0);
        chk({tag, "_beat"},   64'(beat_cnt),    64'd0);
        chk({tag, "_lenerr"}, 64'(len_err),     64'd0);
    endtask

    // Stream n beats with m_ready=1; every beat must appear at the head one
    // cycle after its push. len_err is expected high from beat err_from on.
    task automatic send_pkt(input string tag, input int n, input int last_at,
                            input int base, input int err_from);
        bus.m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 64'(base + i);
            bus.s_last  = (i == last_at);
            tick();
            chk({tag, "_data"},   bus.m_data,          64'(base + i));
            chk({tag, "_last"},   64'(bus.m_last),     64'(i == last_at));
            chk({tag, "_level"},  64'(level),          64'd1);
            chk({tag, "_lenerr"}, 64'(len_err),        64'(i >= err_from));
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        tick();
        chk({tag, "_drained"}, 64'(level), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        clear       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset / idle state.
        chk_idle("reset");
        chk("reset_strb", 64'(bus.m_strb), 64'hFF);

        // One well-formed 32-beat packet.
        send_pkt("pkt32", 32, 31, 0, 1000);
        chk("pkt32_cnt",    64'(pkt_cnt),  64'd1);
        chk("pkt32_beat",   64'(beat_cnt), 64'd0);
        chk("pkt32_lenerr", 64'(len_err),  64'd0);

        // Back-pressure: fill to DEPTH with the DMA stalled.
        do_clear();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 64'(100 + i);
            bus.s_last  = 1'b0;
            tick();
        end
        chk("full_level",  64'(level),       64'd16);
        chk("full_sready", 64'(bus.s_ready), 64'd0);
        chk("full_head",   bus.m_data,       64'd100);
        // Full with s_valid and m_ready: one pop, no push.
        bus.s_data  = 64'd116;
        bus.m_ready = 1'b1;
        tick();
        chk("full_pop_level", 64'(level), 64'd15);
        chk("full_pop_head",  bus.m_data, 64'd101);
        // Input resumes: 116 goes in while 101 leaves.
        tick();
        chk("resume_level", 64'(level), 64'd15);
        chk("resume_head",  bus.m_data, 64'd102);
        bus.s_valid = 1'b0;
        for (int j = 102; j <= 116; j++) begin
            chk("drain_data", bus.m_data, 64'(j));
            tick();
        end
        chk("drain_level",  64'(level),       64'd0);
        chk("drain_mvalid", 64'(bus.m_valid), 64'd0);

        // Short packet sets the sticky error; a good one keeps it set.
        do_clear();
        send_pkt("short", 31, 30, 200, 30);
        chk("short_cnt", 64'(pkt_cnt), 64'd1);
        send_pkt("sticky", 32, 31, 300, 0);
        chk("sticky_cnt",    64'(pkt_cnt), 64'd2);
        chk("sticky_lenerr", 64'(len_err), 64'd1);

        // Long packet: error on the push of beat index 31, all 33 forwarded.
        do_clear();
        send_pkt("long", 33, 32, 400, 31);
        chk("long_cnt",  64'(pkt_cnt),  64'd1);
        chk("long_beat", 64'(beat_cnt), 64'd0);

        // clear beats simultaneous push/pop.
        do_clear();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 64'(8'h50 + i);
            bus.s_last  = (i == 1);
            tick();
        end
        chk("preclr_level",  64'(level),    64'd5);
        chk("preclr_pkt",    64'(pkt_cnt),  64'd1);
        chk("preclr_beat",   64'(beat_cnt), 64'd3);
        chk("preclr_lenerr", 64'(len_err),  64'd1);
        bus.s_data  = 64'h99;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        clear       = 1'b1;
        tick();
        clear       = 1'b0;
        bus.m_ready = 1'b0;
        chk_idle("clear");
        bus.s_data = 64'hAA;
        tick();
        bus.s_valid = 1'b0;
        chk("postclr_level", 64'(level), 64'd1);
        chk("postclr_head",  bus.m_data, 64'hAA);

        // Asynchronous reset mid-packet.
        do_clear();
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 64'(500 + i);
            tick();
        end
        bus.s_valid = 1'b0;
        chk("prerst_level", 64'(level),    64'd3);
        chk("prerst_beat",  64'(beat_cnt), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        tick();
        rst = 1'b0;
        tick();
        chk_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
